// File: rtl/tdc_controller_mc_if.sv
// Result port of the multi-channel TDC controller: one valid/ready stream
// carrying channel index, coarse TOA, coarse TOT and status flags.
interface tdc_controller_mc_if #(
  parameter int NCH   = 4,
  parameter int TOA_W = 6,
  parameter int TOT_W = 6
);
  localparam int CH_W = (NCH > 1) ? $clog2(NCH) : 1;

  logic             out_valid;
  logic             out_ready;
  logic [CH_W-1:0]  out_ch;
  logic [TOA_W-1:0] out_toa;
  logic [TOT_W-1:0] out_tot;
  logic [1:0]       out_flags;

  modport master (
    output out_valid,
    output out_ch,
    output out_toa,
    output out_tot,
    output out_flags,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_ch,
    input  out_toa,
    input  out_tot,
    input  out_flags,
    output out_ready
  );
endinterface

// File: rtl/tdc_controller_mc.sv
// Multi-channel coarse TDC controller in the clk320 domain. Each channel
// synchronises its discriminator pulse, measures TOA against the frame
// counter and TOT in ticks, buffers one finished hit, and a round-robin
// arbiter serialises the buffered hits onto a single valid/ready port.
module tdc_controller_mc #(
  parameter int NCH      = 4,
  parameter int TOA_W    = 6,
  parameter int TOT_W    = 6,
  parameter int DEAD_CYC = 2,
  parameter int TEST_TOA = 10,
  parameter int TEST_TOT = 20
) (
  input  logic                 clk320,
  input  logic                 reset,
  input  logic                 enable_i,
  input  logic                 test_mode_i,
  input  logic                 auto_reset_i,
  input  logic [NCH-1:0]       polarity_sel_i,
  input  logic [NCH-1:0]       pulse_i,
  output logic [TOA_W-1:0]     frame_cnt_o,
  tdc_controller_mc_if.master  result
);

  localparam int CH_W   = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int DEAD_W = (DEAD_CYC > 1) ? $clog2(DEAD_CYC) : 1;

  localparam logic [TOT_W-1:0]  TOT_MAX    = '1;
  localparam logic [TOA_W-1:0]  FRAME_LAST = '1;
  localparam logic [TOA_W-1:0]  TP_START   = TOA_W'(TEST_TOA);
  localparam logic [TOA_W:0]    TP_LEN     = (TOA_W + 1)'(TEST_TOT);
  localparam logic [DEAD_W-1:0] DEAD_LAST  = DEAD_W'(DEAD_CYC - 1);
  localparam logic [CH_W-1:0]   LAST_CH    = CH_W'(NCH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    DEAD = 2'd2
  } chState_e;

  // Frame counter, test pulse and frame-wrap abort
  logic [TOA_W-1:0] frameCnt_q;
  logic [TOA_W-1:0] tpOffset;
  logic             testPulse;
  logic             wrapAbort;

  // Input path
  logic [NCH-1:0] actRaw;
  logic [NCH-1:0] sync1_q, sync2_q, sync3_q;
  logic [NCH-1:0] rise, fall;

  // Channel measurement state
  chState_e                   state_q [NCH];
  chState_e                   state_d [NCH];
  logic [NCH-1:0][TOA_W-1:0]  toa_q, toa_d;
  logic [NCH-1:0][TOT_W-1:0]  tot_q, tot_d;
  logic [NCH-1:0]             sat_q, sat_d;
  logic [NCH-1:0][DEAD_W-1:0] deadCnt_q, deadCnt_d;
  logic [NCH-1:0]             commit;

  // Per-channel hold registers and sticky overflow
  logic [NCH-1:0]             holdFull_q, holdFull_d;
  logic [NCH-1:0][TOA_W-1:0]  holdToa_q, holdToa_d;
  logic [NCH-1:0][TOT_W-1:0]  holdTot_q, holdTot_d;
  logic [NCH-1:0]             holdSat_q, holdSat_d;
  logic [NCH-1:0]             ovf_q, ovf_d;
  logic [NCH-1:0]             dropHit;

  // Arbiter and output register
  logic [CH_W-1:0]  lastGrant_q, lastGrant_d;
  logic [CH_W-1:0]  grantIdx;
  logic             grantFound;
  logic             outLoad;
  logic             doGrant;
  logic [NCH-1:0]   grantVec;
  logic             outValid_q, outValid_d;
  logic [CH_W-1:0]  outCh_q, outCh_d;
  logic [TOA_W-1:0] outToa_q, outToa_d;
  logic [TOT_W-1:0] outTot_q, outTot_d;
  logic [1:0]       outFlags_q, outFlags_d;

  // Free-running frame counter; enable deliberately has no effect on it
  always_ff @(posedge clk320 or posedge reset) begin
    if (reset) frameCnt_q <= '0;
    else       frameCnt_q <= frameCnt_q + 1'b1;
  end

  // Test pulse window measured modulo the frame, plus the auto-reset abort strobe
  always_comb begin
    tpOffset  = frameCnt_q - TP_START;
    testPulse = ({1'b0, tpOffset} < TP_LEN);
    wrapAbort = auto_reset_i && (frameCnt_q == FRAME_LAST);
  end

  // Normalise every channel to active-high and derive edges from the synchronised copy
  always_comb begin
    actRaw = (test_mode_i ? {NCH{testPulse}} : pulse_i) ~^ polarity_sel_i;
    rise   = sync2_q & ~sync3_q;
    fall   = ~sync2_q & sync3_q;
  end

  // Two-flop synchroniser followed by one edge-detect register per channel
  always_ff @(posedge clk320 or posedge reset) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
      sync3_q <= '0;
    end else begin
      sync1_q <= actRaw;
      sync2_q <= sync1_q;
      sync3_q <= sync2_q;
    end
  end

  // Channel FSM next state: arm on rise, count TOT, commit on fall, then sit out dead time
  always_comb begin
    state_d   = state_q;
    toa_d     = toa_q;
    tot_d     = tot_q;
    sat_d     = sat_q;
    deadCnt_d = deadCnt_q;
    commit    = '0;
    for (int c = 0; c < NCH; c++) begin
      if (wrapAbort) begin
        state_d[c] = IDLE;
      end else begin
        case (state_q[c])
          IDLE: begin
            if (enable_i && rise[c]) begin
              state_d[c] = HIGH;
              toa_d[c]   = frameCnt_q;
              tot_d[c]   = TOT_W'(1);
              sat_d[c]   = 1'b0;
            end
          end
          HIGH: begin
            if (fall[c]) begin
              state_d[c]   = DEAD;
              commit[c]    = 1'b1;
              deadCnt_d[c] = '0;
            end else begin
              if (tot_q[c] != TOT_MAX) tot_d[c] = tot_q[c] + 1'b1;
              if (tot_q[c] >= TOT_MAX - 1'b1) sat_d[c] = 1'b1;
            end
          end
          DEAD: begin
            if (deadCnt_q[c] == DEAD_LAST) state_d[c] = IDLE;
            else                           deadCnt_d[c] = deadCnt_q[c] + 1'b1;
          end
          default: state_d[c] = IDLE;
        endcase
      end
    end
  end

  // Channel FSM registers
  always_ff @(posedge clk320 or posedge reset) begin
    if (reset) begin
      for (int c = 0; c < NCH; c++) state_q[c] <= IDLE;
      toa_q     <= '0;
      tot_q     <= '0;
      sat_q     <= '0;
      deadCnt_q <= '0;
    end else begin
      state_q   <= state_d;
      toa_q     <= toa_d;
      tot_q     <= tot_d;
      sat_q     <= sat_d;
      deadCnt_q <= deadCnt_d;
    end
  end

  // Round-robin search for the first full hold strictly after the last grant
  always_comb begin
    grantFound = 1'b0;
    grantIdx   = '0;
    for (int k = 1; k <= NCH; k++) begin
      if (!grantFound && holdFull_q[(int'(lastGrant_q) + k) % NCH]) begin
        grantFound = 1'b1;
        grantIdx   = CH_W'((int'(lastGrant_q) + k) % NCH);
      end
    end
    outLoad  = !outValid_q || result.out_ready;
    doGrant  = outLoad && grantFound;
    grantVec = NCH'(doGrant) << grantIdx;
  end

  // Hold update: a grant frees the slot in time for a same-cycle commit; otherwise a full slot drops the hit
  always_comb begin
    holdFull_d = holdFull_q;
    holdToa_d  = holdToa_q;
    holdTot_d  = holdTot_q;
    holdSat_d  = holdSat_q;
    ovf_d      = ovf_q;
    dropHit    = '0;
    for (int c = 0; c < NCH; c++) begin
      if (grantVec[c]) begin
        holdFull_d[c] = 1'b0;
        ovf_d[c]      = 1'b0;
      end
      if (commit[c]) begin
        if (holdFull_q[c] && !grantVec[c]) begin
          dropHit[c] = 1'b1;
          ovf_d[c]   = 1'b1;
        end else begin
          holdFull_d[c] = 1'b1;
          holdToa_d[c]  = toa_q[c];
          holdTot_d[c]  = tot_q[c];
          holdSat_d[c]  = sat_q[c];
        end
      end
    end
  end

  // Hold registers and sticky overflow bits
  always_ff @(posedge clk320 or posedge reset) begin
    if (reset) begin
      holdFull_q <= '0;
      holdToa_q  <= '0;
      holdTot_q  <= '0;
      holdSat_q  <= '0;
      ovf_q      <= '0;
    end else begin
      holdFull_q <= holdFull_d;
      holdToa_q  <= holdToa_d;
      holdTot_q  <= holdTot_d;
      holdSat_q  <= holdSat_d;
      ovf_q      <= ovf_d;
    end
  end

  // Output register reloads on empty or on a same-cycle transfer, and otherwise holds steady
  always_comb begin
    outValid_d  = outValid_q;
    outCh_d     = outCh_q;
    outToa_d    = outToa_q;
    outTot_d    = outTot_q;
    outFlags_d  = outFlags_q;
    lastGrant_d = lastGrant_q;
    if (doGrant) begin
      outValid_d  = 1'b1;
      outCh_d     = grantIdx;
      outToa_d    = holdToa_q[grantIdx];
      outTot_d    = holdTot_q[grantIdx];
      outFlags_d  = {ovf_q[grantIdx] | dropHit[grantIdx], holdSat_q[grantIdx]};
      lastGrant_d = grantIdx;
    end else if (outValid_q && result.out_ready) begin
      outValid_d = 1'b0;
    end
  end

  // Output and arbiter pointer registers; the pointer restarts so channel 0 is served first
  always_ff @(posedge clk320 or posedge reset) begin
    if (reset) begin
      outValid_q  <= 1'b0;
      outCh_q     <= '0;
      outToa_q    <= '0;
      outTot_q    <= '0;
      outFlags_q  <= '0;
      lastGrant_q <= LAST_CH;
    end else begin
      outValid_q  <= outValid_d;
      outCh_q     <= outCh_d;
      outToa_q    <= outToa_d;
      outTot_q    <= outTot_d;
      outFlags_q  <= outFlags_d;
      lastGrant_q <= lastGrant_d;
    end
  end

  assign frame_cnt_o      = frameCnt_q;
  assign result.out_valid = outValid_q;
  assign result.out_ch    = outCh_q;
  assign result.out_toa   = outToa_q;
  assign result.out_tot   = outTot_q;
  assign result.out_flags = outFlags_q;

endmodule

// File: tb/tb_tdc_controller_mc.sv
// Scoreboard bench for the multi-channel TDC controller: each hit pushes its
// expected result when driven, and a monitor pops and compares on transfer.
`timescale 1ns/1ps
module tb_tdc_controller_mc;

  localparam int NCH   = 4;
  localparam int TOA_W = 6;
  localparam int TOT_W = 6;

  typedef struct {
    int ch;
    int toa;
    int tot;
    int flags;
  } expRes_t;

  logic             clk320 = 1'b0;
  logic             reset;
  logic             enable;
  logic             testMode;
  logic             autoReset;
  logic [NCH-1:0]   polSel;
  logic [NCH-1:0]   actDrive;
  logic [NCH-1:0]   pulse;
  logic [TOA_W-1:0] frameCnt;

  expRes_t expQ[$];
  expRes_t popped;
  int      compared   = 0;
  int      mismatched = 0;

  tdc_controller_mc_if #(.NCH(NCH), .TOA_W(TOA_W), .TOT_W(TOT_W)) resIf ();

  tdc_controller_mc #(
    .NCH(NCH), .TOA_W(TOA_W), .TOT_W(TOT_W),
    .DEAD_CYC(2), .TEST_TOA(10), .TEST_TOT(20)
  ) dut (
    .clk320         (clk320),
    .reset          (reset),
    .enable_i       (enable),
    .test_mode_i    (testMode),
    .auto_reset_i   (autoReset),
    .polarity_sel_i (polSel),
    .pulse_i        (pulse),
    .frame_cnt_o    (frameCnt),
    .result         (resIf)
  );

  // Drive the pin level that makes each channel active exactly when actDrive is set
  assign pulse = ~(actDrive ^ polSel);

  always #2 clk320 = ~clk320;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, wanted %0d", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk320);
    #1;
  endtask

  task automatic waitFrame(input int n);
    int guard = 0;
    while (frameCnt != TOA_W'(n) && guard < 200) begin
      tick();
      guard++;
    end
    if (guard >= 200) checkOutput("frameWait", frameCnt, n);
  endtask

  task automatic pushExp(input int ch, input int toa, input int tot, input int flags);
    expRes_t e;
    e.ch = ch; e.toa = toa; e.tot = tot; e.flags = flags;
    expQ.push_back(e);
  endtask

  // Channel active for len samples starting with the sample taken in frame count 'start'
  task automatic applyStimulus(input int ch, input int start, input int len);
    waitFrame(start);
    actDrive[ch] = 1'b1;
    repeat (len) tick();
    actDrive[ch] = 1'b0;
  endtask

  task automatic waitDrain(input int budget);
    int n = 0;
    while (expQ.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    checkOutput("drain", expQ.size(), 0);
  endtask

  // Scoreboard monitor: sample away from the active edge and compare each transfer
  always @(negedge clk320) begin
    if (!reset && resIf.out_valid && resIf.out_ready) begin
      if (expQ.size() == 0) begin
        checkOutput("spurious", resIf.out_valid, 0);
      end else begin
        popped = expQ.pop_front();
        checkOutput("ch",    resIf.out_ch,    popped.ch);
        checkOutput("toa",   resIf.out_toa,   popped.toa);
        checkOutput("tot",   resIf.out_tot,   popped.tot);
        checkOutput("flags", resIf.out_flags, popped.flags);
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no completion, wanted finish before 200us");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset           = 1'b1;
    enable          = 1'b0;
    testMode        = 1'b0;
    autoReset       = 1'b0;
    polSel          = '1;
    actDrive        = '0;
    resIf.out_ready = 1'b0;
    repeat (3) tick();

    checkOutput("rstFrame", frameCnt, 0);
    checkOutput("rstValid", resIf.out_valid, 0);
    checkOutput("rstCh",    resIf.out_ch, 0);
    checkOutput("rstToa",   resIf.out_toa, 0);
    checkOutput("rstTot",   resIf.out_tot, 0);
    checkOutput("rstFlags", resIf.out_flags, 0);

    reset = 1'b0;
    repeat (70) tick();
    checkOutput("frameWrap", frameCnt, 6);

    enable          = 1'b1;
    resIf.out_ready = 1'b1;

    $display("[TB] basic hit on ch0");
    pushExp(0, 22, 10, 0);
    applyStimulus(0, 20, 10);
    waitDrain(40);

    $display("[TB] active-low ch2, saturating TOT across the frame wrap");
    polSel[2] = 1'b0;
    pushExp(2, 7, 63, 1);
    applyStimulus(2, 5, 70);
    waitDrain(40);
    polSel[2] = 1'b1;

    $display("[TB] enable low blocks arming");
    enable = 1'b0;
    applyStimulus(0, 20, 5);
    repeat (20) tick();
    checkOutput("enableBlock", resIf.out_valid, 0);

    $display("[TB] enable dropping mid-measurement");
    enable = 1'b1;
    pushExp(0, 22, 8, 0);
    fork
      applyStimulus(0, 20, 8);
      begin
        waitFrame(25);
        enable = 1'b0;
      end
    join
    enable = 1'b1;
    waitDrain(40);

    $display("[TB] rising edge inside dead time is ignored");
    pushExp(0, 22, 3, 0);
    applyStimulus(0, 20, 3);
    applyStimulus(0, 24, 5);
    repeat (20) tick();
    waitDrain(10);

    $display("[TB] overflow on ch1 with consumer stalled");
    resIf.out_ready = 1'b0;
    pushExp(1, 12, 5, 0);
    applyStimulus(1, 10, 5);
    pushExp(1, 32, 5, 2);
    applyStimulus(1, 30, 5);
    applyStimulus(1, 50, 5);
    repeat (10) tick();
    checkOutput("stallValid", resIf.out_valid, 1);
    checkOutput("stallToa",   resIf.out_toa, 12);
    repeat (5) tick();
    checkOutput("stallTot",   resIf.out_tot, 5);
    resIf.out_ready = 1'b1;
    waitDrain(40);
    pushExp(1, 12, 5, 0);
    applyStimulus(1, 10, 5);
    waitDrain(40);

    $display("[TB] auto-reset aborts a hit spanning the wrap");
    autoReset = 1'b1;
    applyStimulus(3, 60, 10);
    repeat (30) tick();
    checkOutput("autoRstNoHit", resIf.out_valid, 0);
    autoReset = 1'b0;
    pushExp(3, 62, 10, 0);
    applyStimulus(3, 60, 10);
    waitDrain(40);

    $display("[TB] reset during a measurement with a pending result");
    resIf.out_ready = 1'b0;
    applyStimulus(1, 10, 5);
    waitFrame(30);
    actDrive[0] = 1'b1;
    waitFrame(36);
    checkOutput("pendingValid", resIf.out_valid, 1);
    reset = 1'b1;
    #1;
    checkOutput("rstMidValid", resIf.out_valid, 0);
    checkOutput("rstMidFrame", frameCnt, 0);
    actDrive = '0;
    expQ.delete();
    resIf.out_ready = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    repeat (40) tick();
    checkOutput("noStale", resIf.out_valid, 0);

    $display("[TB] test pulse on all channels for two frames");
    waitFrame(45);
    testMode = 1'b1;
    for (int f = 0; f < 2; f++)
      for (int c = 0; c < NCH; c++)
        pushExp(c, 12, 20, 0);
    waitDrain(200);
    waitFrame(45);
    testMode = 1'b0;

    repeat (20) tick();
    checkOutput("sbEmpty", expQ.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
